// File: rtl/mult_arb_pkg.sv
// Shared defaults, requester identity and in-flight tag types for the
// round-robin multiplier arbiter.
package mult_arb_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LATENCY = 3;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // One in-flight operation: whether the slot is occupied and who issued it.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, id: REQ0};

  function automatic tag_t issue_tag(input req_id_t id);
    return '{valid: 1'b1, id: id};
  endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// Fixed-depth shift register of requester tags that travels alongside the
// external multiplier pipeline so each product can be routed back.
module mult_tag_pipe
  import mult_arb_pkg::*;
#(
  parameter int DEPTH = DEF_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tail_o,
  output logic any_valid_o
);

  tag_t stage_q [DEPTH];

  // Shift one stage per cycle; there is no stall path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this is a shift register, not a RAM, so every stage is reset;
      // dropping in-flight tags is what cancels operations on reset.
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      // NOTE: non-blocking assignments make each stage read its neighbour's
      // pre-edge value, so the loop order does not matter.
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_o = stage_q[DEPTH-1];

  // Any occupied stage means a product is still on its way.
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid_o = any_valid_o | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external pipelined multiplier between two
// requesters. The granted pair is registered onto the multiplier inputs and a
// tag follows it through the multiplier latency to steer the product back.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_prod,
  output logic               rsp0_valid,
  output logic [2*WIDTH-1:0] rsp0_data,
  output logic               rsp1_valid,
  output logic [2*WIDTH-1:0] rsp1_data,
  output logic               busy
);

  logic             grant0, grant1;
  req_id_t          last_q, last_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  tag_t             tag_q, tag_d;
  tag_t             tail;
  logic             pipe_busy;

  // Grant: a lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (last_q == REQ1));
    grant1 = req1_valid && (!req0_valid || (last_q == REQ0));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next operands, stage-0 tag and priority pointer from this cycle's accept.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    mul_a_d = '0;
    mul_b_d = '0;
    tag_d   = TAG_NONE;
    last_d  = last_q;
    if (grant0) begin
      mul_a_d = req0_a;
      mul_b_d = req0_b;
      tag_d   = issue_tag(REQ0);
      last_d  = REQ0;
    end else if (grant1) begin
      mul_a_d = req1_a;
      mul_b_d = req1_b;
      tag_d   = issue_tag(REQ1);
      last_d  = REQ1;
    end
  end

  // Operand registers, stage-0 tag and pointer; reset makes req0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      tag_q   <= TAG_NONE;
      last_q  <= REQ1;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  // The tag sits in tag_q while the operands sit on the multiplier inputs,
  // then rides LATENCY more stages so it retires with its product.
  mult_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag_q),
    .tail_o      (tail),
    .any_valid_o (pipe_busy)
  );

  assign busy = tag_q.valid | pipe_busy;

  // Response demux: the retiring tag selects which requester sees the product.
  always_comb begin
    rsp0_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_valid = 1'b0;
    rsp1_data  = '0;
    if (tail.valid) begin
      if (tail.id == REQ0) begin
        rsp0_valid = 1'b1;
        rsp0_data  = mul_prod;
      end else begin
        rsp1_valid = 1'b1;
        rsp1_data  = mul_prod;
      end
    end
  end

endmodule
